// File: rtl/torpedo_scheduler.sv
// Torpedo launch scheduler: turns fire-button edges into one-hot launch pulses
// over round-robin slots, with a frame-based cooldown and per-slot flight timeout.
module torpedo_scheduler #(
  parameter int T_NUM           = 4,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int LIFE_FRAMES     = 60
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         vsync_i,
  input  logic                         fire_i,
  input  logic [T_NUM-1:0]             slot_done_i,
  output logic [T_NUM-1:0]             launch_o,
  output logic [T_NUM-1:0]             busy_o,
  output logic [$clog2(T_NUM+1)-1:0]   free_cnt_o,
  output logic                         drop_o,
  output logic                         cooling_o
);

  localparam int PW = (T_NUM > 1) ? $clog2(T_NUM) : 1;
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int LW = $clog2(LIFE_FRAMES + 1);
  localparam int FW = $clog2(T_NUM + 1);

  typedef enum logic {READY, COOLDOWN} state_e;

  state_e           state_q;
  logic             fire_d_q;
  logic             armed_q;
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cool_q;
  logic [LW-1:0]    life_q [T_NUM];
  logic [LW-1:0]    life_d [T_NUM];
  logic [T_NUM-1:0] busy_q, busy_d;
  logic [T_NUM-1:0] launch_q;
  logic             drop_q;
  logic [FW-1:0]    free_q, free_d;

  logic [PW-1:0]    scan_idx;
  logic [PW-1:0]    sel_idx;
  logic             sel_found;
  logic             fire_edge;
  logic             do_launch;
  logic             do_drop;

  // armed_q keeps a fire level already high at reset release from counting as an edge
  assign fire_edge = fire_i & ~fire_d_q & armed_q;
  assign do_launch = (state_q == READY) & fire_edge & sel_found;
  assign do_drop   = (state_q == READY) & fire_edge & ~sel_found;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int j = 0; j < T_NUM; j++) begin
      scan_idx = PW'((int'(ptr_q) + 1 + j) % T_NUM);
      if (!sel_found && !busy_q[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // A launched slot is never busy, so launch never collides with done/timeout on it
  always_comb begin
    busy_d = busy_q;
    free_d = FW'(T_NUM);
    for (int i = 0; i < T_NUM; i++) begin
      life_d[i] = life_q[i];
      if (do_launch && sel_idx == PW'(i)) begin
        busy_d[i] = 1'b1;
        life_d[i] = LW'(LIFE_FRAMES);
      end else if (busy_q[i]) begin
        if (slot_done_i[i]) begin
          busy_d[i] = 1'b0;
          life_d[i] = '0;
        end else if (vsync_i) begin
          life_d[i] = life_q[i] - LW'(1);
          if (life_q[i] == LW'(1)) busy_d[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < T_NUM; i++) begin
      if (busy_d[i]) free_d = free_d - FW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= READY;
      fire_d_q <= 1'b0;
      armed_q  <= 1'b0;
      ptr_q    <= PW'(T_NUM - 1);
      cool_q   <= '0;
      busy_q   <= '0;
      launch_q <= '0;
      drop_q   <= 1'b0;
      free_q   <= FW'(T_NUM);
      for (int i = 0; i < T_NUM; i++) life_q[i] <= '0;
    end else begin
      fire_d_q <= fire_i;
      armed_q  <= 1'b1;
      busy_q   <= busy_d;
      life_q   <= life_d;
      free_q   <= free_d;
      drop_q   <= do_drop;
      launch_q <= '0;
      if (do_launch) begin
        launch_q[sel_idx] <= 1'b1;
        ptr_q             <= sel_idx;
      end
      case (state_q)
        READY: begin
          if (do_launch && COOLDOWN_FRAMES > 0) begin
            state_q <= COOLDOWN;
            cool_q  <= CW'(COOLDOWN_FRAMES);
          end
        end
        COOLDOWN: begin
          if (cool_q == '0) state_q <= READY;
          else if (vsync_i) cool_q <= cool_q - CW'(1);
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign launch_o   = launch_q;
  assign busy_o     = busy_q;
  assign free_cnt_o = free_q;
  assign drop_o     = drop_q;
  assign cooling_o  = (state_q == COOLDOWN);

endmodule

// File: tb/tb_torpedo_scheduler.sv
// Scoreboard bench for torpedo_scheduler: directed scenarios plus random traffic
// checked against a frame/slot-level reference model.
module tb_torpedo_scheduler;

  localparam int T    = 4;
  localparam int COOL = 6;
  localparam int LIFE = 60;

  logic           clk;
  logic           rst_ni;
  logic           vsync;
  logic           fire;
  logic [T-1:0]   slotDone;
  logic [T-1:0]   launch_o;
  logic [T-1:0]   busy_o;
  logic [2:0]     free_cnt_o;
  logic           drop_o;
  logic           cooling_o;

  torpedo_scheduler #(.T_NUM(T), .COOLDOWN_FRAMES(COOL), .LIFE_FRAMES(LIFE)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .vsync_i     (vsync),
    .fire_i      (fire),
    .slot_done_i (slotDone),
    .launch_o    (launch_o),
    .busy_o      (busy_o),
    .free_cnt_o  (free_cnt_o),
    .drop_o      (drop_o),
    .cooling_o   (cooling_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [4:0] val;
  } exp_t;

  exp_t       expQ[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // Reference model: remaining flight frames per slot (0 = free), cooldown frames left (-1 = ready)
  int         lifeLeft[T];
  int         coolLeft;
  int         lastSlot;
  bit         prevFire;
  bit         armedM;
  logic [T-1:0] expBusy;
  int         expFree;
  bit         expCool;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void modelExpose();
    expBusy = '0;
    expFree = 0;
    for (int i = 0; i < T; i++) begin
      if (lifeLeft[i] > 0) expBusy[i] = 1'b1;
      else expFree++;
    end
    expCool = (coolLeft >= 0);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < T; i++) lifeLeft[i] = 0;
    coolLeft = -1;
    lastSlot = T - 1;
    prevFire = 1'b0;
    armedM   = 1'b0;
    expQ.delete();
    modelExpose();
  endfunction

  function automatic void modelStep(input bit v, input bit f, input logic [T-1:0] d);
    bit edgeSeen;
    int launched;
    int k;
    exp_t e;
    edgeSeen = f && !prevFire && armedM;
    prevFire = f;
    armedM   = 1'b1;
    launched = -1;
    if (coolLeft < 0 && edgeSeen) begin
      for (int j = 1; j <= T; j++) begin
        k = (lastSlot + j) % T;
        if (launched < 0 && lifeLeft[k] == 0) launched = k;
      end
      e.due = cyc + 1;
      if (launched >= 0) e.val = 5'((1 << launched) << 1);
      else e.val = 5'b00001;
      expQ.push_back(e);
    end
    for (int i = 0; i < T; i++) begin
      if (i == launched) lifeLeft[i] = LIFE;
      else if (lifeLeft[i] > 0) begin
        if (d[i]) lifeLeft[i] = 0;
        else if (v) lifeLeft[i] = lifeLeft[i] - 1;
      end
    end
    if (coolLeft < 0) begin
      if (launched >= 0 && COOL > 0) coolLeft = COOL;
    end else if (coolLeft == 0) coolLeft = -1;
    else if (v) coolLeft = coolLeft - 1;
    if (launched >= 0) lastSlot = launched;
    modelExpose();
  endfunction

  task automatic applyStimulus(input bit v, input bit f, input logic [T-1:0] d);
    @(negedge clk);
    vsync    = v;
    fire     = f;
    slotDone = d;
    if (rst_ni) modelStep(v, f, d);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      applyStimulus(1'b1, 1'b0, '0);
      idle(3);
    end
  endtask

  task automatic pulseFire();
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic resetAssert();
    rst_ni = 1'b0;
    modelReset();
  endtask

  task automatic resetRelease();
    @(negedge clk);
    rst_ni = 1'b1;
    modelStep(vsync, fire, slotDone);
  endtask

  task automatic doReset();
    @(negedge clk);
    vsync    = 1'b0;
    fire     = 1'b0;
    slotDone = '0;
    resetAssert();
    repeat (2) @(negedge clk);
    resetRelease();
  endtask

  // Monitor: pops the scoreboard when a response is due, flags any unexpected pulse
  initial begin
    logic [4:0] got;
    exp_t       e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_ni) begin
        got = {launch_o, drop_o};
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
          e = expQ.pop_front();
          checkOutput("launch_drop", 32'(got), 32'(e.val));
        end else if (got != 5'b0) begin
          checkOutput("unexpected_pulse", 32'(got), 32'd0);
        end
        checkOutput("busy", 32'(busy_o), 32'(expBusy));
        checkOutput("free_cnt", 32'(free_cnt_o), 32'(expFree));
        checkOutput("cooling", 32'(cooling_o), 32'(expCool));
      end
    end
  end

  initial begin
    rst_ni   = 1'b0;
    vsync    = 1'b0;
    fire     = 1'b0;
    slotDone = '0;
    modelReset();

    // First launch after reset goes to slot 0 and starts cooldown
    doReset();
    pulseFire();
    checkOutput("first_launch", 32'(launch_o), 32'h1);
    checkOutput("first_busy", 32'(busy_o), 32'h1);
    checkOutput("first_free", 32'(free_cnt_o), 32'd3);
    checkOutput("first_cooling", 32'(cooling_o), 32'd1);
    idle(1);
    checkOutput("launch_one_cycle", 32'(launch_o), 32'h0);

    // Round robin over all slots, then a drop when full
    frames(7);
    pulseFire();
    checkOutput("rr_launch1", 32'(launch_o), 32'h2);
    frames(7);
    pulseFire();
    checkOutput("rr_launch2", 32'(launch_o), 32'h4);
    frames(7);
    pulseFire();
    checkOutput("rr_launch3", 32'(launch_o), 32'h8);
    frames(7);
    pulseFire();
    checkOutput("full_drop", 32'(drop_o), 32'd1);
    checkOutput("full_no_launch", 32'(launch_o), 32'h0);
    checkOutput("full_busy", 32'(busy_o), 32'hF);

    // Slot freed in the same cycle as the edge is not yet selectable
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("done_same_cycle_drop", 32'(drop_o), 32'd1);
    checkOutput("done_busy", 32'(busy_o), 32'hB);
    pulseFire();
    checkOutput("refire_slot2", 32'(launch_o), 32'h4);

    // Edges during cooldown are ignored
    doReset();
    pulseFire();
    frames(2);
    pulseFire();
    checkOutput("cool_ignore_launch", 32'(launch_o), 32'h0);
    checkOutput("cool_ignore_drop", 32'(drop_o), 32'd0);
    frames(4);
    pulseFire();
    checkOutput("cool_done_launch", 32'(launch_o), 32'h2);

    // Flight timeout after LIFE vsyncs
    doReset();
    pulseFire();
    frames(LIFE - 1);
    checkOutput("life_still_busy", 32'(busy_o), 32'h1);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("life_timeout_busy", 32'(busy_o), 32'h0);
    checkOutput("life_timeout_free", 32'(free_cnt_o), 32'd4);

    // Reset mid-cooldown while launch is high, fire held across release
    doReset();
    pulseFire();
    frames(7);
    pulseFire();
    checkOutput("pre_reset_launch", 32'(launch_o), 32'h2);
    checkOutput("pre_reset_busy", 32'(busy_o), 32'h3);
    resetAssert();
    #1;
    checkOutput("rst_launch", 32'(launch_o), 32'h0);
    checkOutput("rst_drop", 32'(drop_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_free", 32'(free_cnt_o), 32'd4);
    checkOutput("rst_cooling", 32'(cooling_o), 32'd0);
    fire = 1'b1;
    repeat (2) @(negedge clk);
    resetRelease();
    repeat (5) applyStimulus(1'b0, 1'b1, '0);
    checkOutput("held_fire_no_launch", 32'(launch_o), 32'h0);
    idle(1);
    pulseFire();
    checkOutput("post_reset_slot0", 32'(launch_o), 32'h1);

    // Random traffic with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      logic [T-1:0] d;
      for (int b = 0; b < T; b++) d[b] = ($urandom_range(0, 19) == 0);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, d);
      if (i == 1500) doReset();
    end

    idle(3);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/torpedo_scheduler.md
TORPEDO_SCHEDULER -- requirements
Module: torpedo_scheduler

Interface
REQ-001 Parameter T_NUM, default 4: number of torpedo slots.
REQ-002 Parameter COOLDOWN_FRAMES, default 6: minimum frames between launches; 0 = no cooldown.
REQ-003 Parameter LIFE_FRAMES, default 60: maximum flight time per slot in frames, >=1.
REQ-004 clk  in  1  system pixel clock (25 MHz); all state on rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 vsync  in  1  one-cycle frame-start pulse.
REQ-007 fire  in  1  fire button level (A), already synchronous to clk.
REQ-008 slot_done  in  T_NUM  per-slot one-cycle pulse: torpedo hit or left the screen.
REQ-009 launch  out  T_NUM  one-hot one-cycle launch pulse to the selected slot.
REQ-010 busy  out  T_NUM  per-slot in-flight flag.
REQ-011 free_cnt  out  $clog2(T_NUM+1)  number of clear bits in busy.
REQ-012 drop  out  1  one-cycle pulse: fire edge accepted but no free slot.
REQ-013 cooling  out  1  high while in COOLDOWN.

Function
REQ-014 Fire edge = fire & ~fire_d, where fire_d is fire registered once; only rising edges count, holding fire never auto-repeats.
REQ-015 FSM states READY, COOLDOWN; reset state READY.
REQ-016 READY, edge at cycle N, some busy bit clear -> launch[k] high during cycle N+1 only, busy[k] set at N+1, go COOLDOWN (or stay READY if COOLDOWN_FRAMES=0).
REQ-017 READY, edge at cycle N, all busy set -> drop high during N+1 only, no launch, stay READY, no cooldown load.
REQ-018 COOLDOWN: fire edges ignored, not queued, no drop.
REQ-019 Cooldown counter loaded with COOLDOWN_FRAMES on launch; decremented on each vsync; reaching 0 -> READY on the next cycle.
REQ-020 Slot selection is round-robin: search starts at index (last_launched+1) mod T_NUM, first clear busy bit wins; pointer resets to T_NUM-1 so the first launch uses slot 0.
REQ-021 Free mask is the registered busy vector; a slot freed by slot_done in cycle N is selectable from cycle N+1.
REQ-022 Per-slot life counter loaded with LIFE_FRAMES on launch; decremented on vsync while busy; reaching 0 clears busy (timeout).
REQ-023 Launch load has priority over vsync decrement in the same cycle.
REQ-024 slot_done[i] clears busy[i] on the next edge; slot_done on a non-busy slot is ignored.
REQ-025 slot_done[i] and timeout of slot i in the same cycle produce a single clear.
REQ-026 free_cnt tracks busy with one cycle of latency at most; never exceeds T_NUM.
REQ-027 launch and drop never assert in the same cycle; launch has at most one bit set.

Reset
REQ-028 Asserting resetN low at any time, including mid-cooldown or with launch high: launch=0, drop=0, busy=0, free_cnt=T_NUM, cooling=0, FSM=READY, counters=0, fire_d=0, pointer=T_NUM-1.
REQ-029 After release, fire already high does not count as an edge until it falls and rises again (fire_d is loaded from fire on the first clock after release).

Verification
REQ-030 Reset, pulse fire once -> launch=4'b0001 for one cycle, one cycle after the edge; busy=0001; free_cnt=3; cooling=1.
REQ-031 Four edges, each spaced 7 vsyncs apart -> launches 0001,0010,0100,1000 in that order; fifth edge -> drop pulse, busy=1111.
REQ-032 Edge 2 vsyncs after a launch -> no launch, no drop; edge after 6 vsyncs -> launch accepted.
REQ-033 Launch slot 0, no slot_done, 60 vsyncs -> busy[0] clears after the 60th vsync; free_cnt returns to 4.
REQ-034 All busy; slot_done[2] in cycle N and fire edge in cycle N -> drop; repeat edge after cooldown -> launch=0100.
REQ-035 Reset asserted mid-cooldown with busy=0011 -> all outputs at reset values immediately; fire held high across release -> no launch.
